// File: rtl/i2s_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_serializer_pkg
//  Description : Definitions shared by the I2S transmit path: word-select
//                slot encodings, the serializer state encoding and the
//                sample-size decode that is also used by the receive path.
//  Contents    : I2S_LEFT / I2S_RIGHT  - ws value of each slot
//                tx_state_t            - serializer states
//                decode_sample_size()  - 5-bit size field -> bit count
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_tx_serializer_pkg;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } tx_state_t;

    // A size field of 0 stands for a full 32-bit sample, so the result needs
    // six bits.
    function automatic logic [5:0] decode_sample_size(input logic [4:0] size);
        decode_sample_size = (size == 5'd0) ? 6'd32 : {1'b0, size};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_fifo
//  Description : First-word-fall-through sample FIFO. The head entry is
//                always present on o_rdata while the FIFO is non-empty.
//                Writes while full are dropped; reads while empty are ignored.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_wr, i_wdata   - push request and data
//                i_rd            - pop request (head consumed this cycle)
//                o_rdata         - head entry
//                o_full/o_empty  - status flags
//                o_level         - entry count, 0..2^FIFO_AW
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_fifo #(
    parameter int FIFO_AW = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic               i_rd,
    output logic [DATA_W-1:0]  o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_level
);

    localparam int               c_depth   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_level_full = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_W-1:0]  r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_level == c_level_full);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_wr & ~o_full;
    assign w_pop  = i_rd & ~o_empty;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the level unchanged.
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_serializer
//  Description : I2S transmit stage. Samples pushed into an internal FIFO are
//                shifted out MSB-first on sdo, aligned to the sck/ws pair of
//                the clock generator. Supports I2S (one-bit delay) and
//                left-justified framing, 1..32-bit samples and per-channel
//                enables.
//  Ports       : clk, rst_n            - clock, asynchronous active-low reset
//                en                    - transmit enable
//                sck, ws               - serial clock / word select (0=left)
//                sdo                   - registered serial data
//                left_justified        - framing select
//                sample_size           - bits per sample, 0 means 32
//                channels              - {left_en, right_en}
//                fifo_wr, fifo_wdata   - sample push
//                fifo_full/empty/level - FIFO status
//                fifo_level_threshold  - low-water mark
//                fifo_level_below      - level below low-water mark
//                underrun, underrun_clr- sticky underrun flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sck,
    input  logic               ws,
    output logic               sdo,
    input  logic               left_justified,
    input  logic [4:0]         sample_size,
    input  logic [1:0]         channels,
    input  logic               fifo_wr,
    input  logic [31:0]        fifo_wdata,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_level,
    input  logic [FIFO_AW:0]   fifo_level_threshold,
    output logic               fifo_level_below,
    output logic               underrun,
    input  logic               underrun_clr
);

    import i2s_tx_serializer_pkg::*;

    logic        r_last_sck;
    logic        r_last_ws;
    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [31:0] r_shreg;
    logic [31:0] w_shreg_nxt;
    logic [5:0]  r_bit_cnt;
    logic [5:0]  w_bit_cnt_nxt;
    logic        r_sdo;
    logic        w_sdo_nxt;
    logic        r_underrun;
    logic        w_underrun_nxt;

    logic        w_sck_fall;
    logic        w_ws_edge;
    logic        w_slot_start;
    logic        w_chan_en;
    logic        w_pop;
    logic        w_underrun_set;
    logic [5:0]  w_n;
    logic [5:0]  w_align;
    logic [31:0] w_head;
    logic [31:0] w_load;

    i2s_tx_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (fifo_wr),
        .i_wdata (fifo_wdata),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_level)
    );

    assign fifo_level_below = (fifo_level < fifo_level_threshold);
    assign underrun         = r_underrun;
    assign sdo              = r_sdo;

    assign w_sck_fall   = ~sck & r_last_sck;
    assign w_ws_edge    = ws ^ r_last_ws;
    assign w_slot_start = w_ws_edge & en;

    // The new slot belongs to the channel named by the new ws value.
    assign w_chan_en      = (ws == I2S_LEFT) ? channels[1] : channels[0];
    assign w_pop          = w_slot_start & w_chan_en & ~fifo_empty;
    assign w_underrun_set = w_slot_start & w_chan_en & fifo_empty;

    // MSB-align the right-aligned sample so shreg[31] is always the next bit.
    assign w_n     = decode_sample_size(sample_size);
    assign w_align = 6'd32 - w_n;
    assign w_load  = w_pop ? (w_head << w_align) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sck <= 1'b0;
            r_last_ws  <= 1'b0;
            r_state    <= ST_IDLE;
            r_shreg    <= 32'd0;
            r_bit_cnt  <= 6'd0;
            r_sdo      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_last_sck <= sck;
            r_last_ws  <= ws;
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sdo      <= w_sdo_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sdo_nxt     = r_sdo;
        // A new underrun takes priority over a clear in the same cycle.
        w_underrun_nxt = w_underrun_set | (r_underrun & ~underrun_clr);

        if (!en) begin
            w_state_nxt   = ST_IDLE;
            w_shreg_nxt   = 32'd0;
            w_bit_cnt_nxt = 6'd0;
            w_sdo_nxt     = 1'b0;
        end else if (w_slot_start) begin
            w_shreg_nxt = w_load;
            if (left_justified) begin
                // MSB goes out on the sck fall that opens the slot.
                w_state_nxt   = ST_SHIFT;
                w_sdo_nxt     = w_load[31];
                w_bit_cnt_nxt = 6'd1;
            end else begin
                // I2S: this fall keeps the previous slot's last bit on sdo.
                w_state_nxt   = ST_DELAY;
                w_bit_cnt_nxt = 6'd0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_sdo_nxt = 1'b0;
                end
                ST_DELAY: begin
                    if (w_sck_fall) begin
                        w_sdo_nxt     = r_shreg[31];
                        w_bit_cnt_nxt = 6'd1;
                        w_state_nxt   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sck_fall) begin
                        if (r_bit_cnt >= w_n) begin
                            w_state_nxt = ST_PAD;
                            w_sdo_nxt   = 1'b0;
                        end else begin
                            w_shreg_nxt   = {r_shreg[30:0], 1'b0};
                            w_sdo_nxt     = r_shreg[30];
                            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                        end
                    end
                end
                ST_PAD: begin
                    w_sdo_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sdo_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_serializer
//  Description : Self-checking bench for i2s_tx_serializer. The bench plays
//                the clock generator (sck half-period of 4 clk, 32 sck periods
//                per slot, ws changing together with the sck fall) and models
//                the transmitter as a queue of samples plus a per-slot list of
//                expected bit values, one per sck period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_serializer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int H     = 4;
    localparam int W     = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sck = 1'b1;
    logic        ws = 1'b1;
    logic        lj = 1'b0;
    logic [4:0]  sample_size = 5'd16;
    logic [1:0]  channels = 2'b11;
    logic        fifo_wr = 1'b0;
    logic [31:0] fifo_wdata = 32'd0;
    logic [AW:0] thr = 5'd4;
    logic        underrun_clr = 1'b0;

    logic        sdo;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;
    logic        fifo_level_below;
    logic        underrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_q[$];
    logic        m_underrun = 1'b0;
    logic        m_carry = 1'b0;

    i2s_tx_serializer #(.FIFO_AW(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .en                   (en),
        .sck                  (sck),
        .ws                   (ws),
        .sdo                  (sdo),
        .left_justified       (lj),
        .sample_size          (sample_size),
        .channels             (channels),
        .fifo_wr              (fifo_wr),
        .fifo_wdata           (fifo_wdata),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_level           (fifo_level),
        .fifo_level_threshold (thr),
        .fifo_level_below     (fifo_level_below),
        .underrun             (underrun),
        .underrun_clr         (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] d);
        @(posedge clk); #1;
        fifo_wr = 1'b1;
        fifo_wdata = d;
        @(posedge clk); #1;
        fifo_wr = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back(d);
    endtask

    // One sck period: fall (with the new ws), sample sdo late in the low
    // phase, then the high phase.
    task automatic do_period(input logic new_ws, input logic clr, output logic s);
        @(posedge clk); #1;
        sck = 1'b0;
        ws = new_ws;
        underrun_clr = clr;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        repeat (H - 2) @(posedge clk);
        #1;
        s = sdo;
        @(posedge clk); #1;
        sck = 1'b1;
        repeat (H - 1) @(posedge clk);
    endtask

    // Plays one slot of nper sck periods and checks every period's bit, then
    // the FIFO level and underrun flag.
    task automatic run_slot(input logic ch, input int nper, input logic clr_start, input string tag);
        int          n;
        logic [31:0] d;
        logic        ch_en;
        logic [W-1:0] expv;
        logic        s;
        n = (sample_size == 5'd0) ? 32 : int'(sample_size);
        ch_en = (ch == 1'b0) ? channels[1] : channels[0];
        d = 32'd0;
        if (clr_start) m_underrun = 1'b0;
        if (ch_en) begin
            if (m_q.size() > 0) d = m_q.pop_front();
            else m_underrun = 1'b1;
        end
        for (int k = 0; k < W; k++) begin
            if (lj) expv[k] = (k < n) ? d[n - 1 - k] : 1'b0;
            else if (k == 0) expv[k] = m_carry;
            else expv[k] = (k <= n) ? d[n - k] : 1'b0;
        end
        for (int k = 0; k < nper; k++) begin
            do_period(ch, clr_start && (k == 0), s);
            n_total++;
            if (s !== expv[k])
                $display("FAIL %s ch%0d sdo bit %0d: got %b expected %b", tag, ch, k, s, expv[k]);
            else n_pass++;
        end
        m_carry = expv[nper - 1];
        #1;
        n_total++;
        if (fifo_level !== 5'(m_q.size()))
            $display("FAIL %s ch%0d level: got %0d expected %0d", tag, ch, fifo_level, m_q.size());
        else n_pass++;
        n_total++;
        if (underrun !== m_underrun)
            $display("FAIL %s ch%0d underrun: got %b expected %b", tag, ch, underrun, m_underrun);
        else n_pass++;
    endtask

    task automatic run_frames(input int nf, input string tag);
        for (int f = 0; f < nf; f++) begin
            run_slot(1'b0, W, 1'b0, tag);
            run_slot(1'b1, W, 1'b0, tag);
        end
    endtask

    // Idle with en=0, bring ws to the right slot, apply config, clear the
    // underrun flag, then enable; the next left slot is the first one sent.
    task automatic prep(input logic lj_v, input logic [4:0] size_v, input logic [1:0] ch_v);
        logic s;
        en = 1'b0;
        if (ws == 1'b0) do_period(1'b1, 1'b0, s);
        lj = lj_v;
        sample_size = size_v;
        channels = ch_v;
        @(posedge clk); #1;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        m_underrun = 1'b0;
        m_carry = 1'b0;
        en = 1'b1;
    endtask

    task automatic check_below(input string tag);
        thr = 5'($urandom_range(0, DEPTH));
        #1;
        n_total++;
        if (fifo_level_below !== (m_q.size() < int'(thr)))
            $display("FAIL %s below: got %b expected %b (thr %0d)", tag, fifo_level_below,
                     (m_q.size() < int'(thr)), thr);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        thr = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (sdo !== 1'b0) $display("FAIL reset sdo: got %b expected 0", sdo); else n_pass++;
        n_total++;
        if (fifo_empty !== 1'b1) $display("FAIL reset empty: got %b expected 1", fifo_empty); else n_pass++;
        n_total++;
        if (fifo_full !== 1'b0) $display("FAIL reset full: got %b expected 0", fifo_full); else n_pass++;
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL reset level: got %0d expected 0", fifo_level); else n_pass++;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL reset underrun: got %b expected 0", underrun); else n_pass++;
        n_total++;
        if (fifo_level_below !== 1'b1) $display("FAIL reset below: got %b expected 1", fifo_level_below); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_i2s_stereo();
        prep(1'b0, 5'd16, 2'b11);
        push(32'h0000_A5C3);
        push(32'h0000_3C5A);
        for (int i = 0; i < 4; i++) push($urandom);
        check_below("i2s");
        run_frames(3, "i2s");
    endtask

    task automatic test_left_justified();
        prep(1'b1, 5'd16, 2'b11);
        push(32'h0000_A5C3);
        push(32'h0000_3C5A);
        for (int i = 0; i < 4; i++) push($urandom);
        run_frames(3, "lj");
    endtask

    task automatic test_n32();
        prep(1'b1, 5'd0, 2'b11);
        push(32'h8000_0001);
        for (int i = 0; i < 3; i++) push($urandom);
        run_frames(2, "n32");
    endtask

    task automatic test_left_only();
        prep(1'b0, 5'd16, 2'b10);
        for (int i = 0; i < 3; i++) push($urandom);
        run_frames(3, "left_only");
    endtask

    task automatic test_random_cfg();
        logic lj_v;
        for (int c = 0; c < 3; c++) begin
            lj_v = 1'($urandom_range(0, 1));
            prep(lj_v, lj_v ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31)), 2'b11);
            for (int i = 0; i < 4; i++) push($urandom);
            check_below("rand");
            run_frames(2, "rand");
        end
    endtask

    task automatic test_underrun();
        prep(1'b0, 5'd16, 2'b11);
        run_frames(1, "underrun");
        @(posedge clk); #1;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        m_underrun = 1'b0;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL underrun_clr: got %b expected 0", underrun); else n_pass++;
        run_slot(1'b0, W, 1'b1, "underrun_setclr");
        run_slot(1'b1, W, 1'b0, "underrun_setclr");
    endtask

    task automatic test_full_disable();
        prep(1'b1, 5'd16, 2'b11);
        push(32'hFFFF_FFFF);
        for (int i = 0; i < DEPTH; i++) push($urandom);
        n_total++;
        if (fifo_full !== 1'b1) $display("FAIL full flag: got %b expected 1", fifo_full); else n_pass++;
        n_total++;
        if (fifo_level !== 5'd16) $display("FAIL full level: got %0d expected 16", fifo_level); else n_pass++;
        n_total++;
        if (fifo_empty !== 1'b0) $display("FAIL full empty: got %b expected 0", fifo_empty); else n_pass++;
        check_below("full");
        run_slot(1'b0, 5, 1'b0, "midslot");
        en = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (sdo !== 1'b0) $display("FAIL disable sdo: got %b expected 0", sdo); else n_pass++;
        n_total++;
        if (fifo_level !== 5'(m_q.size()))
            $display("FAIL disable level: got %0d expected %0d", fifo_level, m_q.size());
        else n_pass++;
        prep(1'b1, 5'd16, 2'b11);
        run_frames(8, "drain");
    endtask

    initial begin
        test_reset();
        test_i2s_stereo();
        test_left_justified();
        test_n32();
        test_left_only();
        test_random_cfg();
        test_underrun();
        test_full_disable();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
